updown_seq_checker: RTL
=======================

Name: updown_seq_checker

Overview:
Downstream consumer of the up/down counter FSM output. Samples the counter value each valid cycle and checks that it follows a legal triangle sequence: +1 steps up to MAX, -1 steps down to MIN, reversing at each bound. Reports direction, lock status, sequence errors and turnaround counts. It sits beside the counter as a self-checking monitor and is synthesizable for on-chip debug.

Parameters:
WIDTH, 4, counter value width
MAX_VAL, 15, upper turnaround value; must be less than or equal to 2^WIDTH-1
MIN_VAL, 0, lower turnaround value; must be less than MAX_VAL
ERR_W, 8, width of error counter (saturating)
TURN_W, 8, width of turnaround counter (wrapping)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
clear  in  1  synchronous clear of counters and FSM; lower priority than rst
in_valid  in  1  count sample is valid this cycle
count  in  WIDTH  counter value from upstream up/down FSM
locked  out  1  checker has a known direction and is tracking
dir_up  out  1  1 = next expected step is +1; meaningful only when locked=1
err  out  1  one-cycle pulse: the previously accepted sample violated the sequence
err_cnt  out  ERR_W  number of violations, saturates at all-ones
turn_cnt  out  TURN_W  number of legal reversals at MAX_VAL or MIN_VAL, wraps
last_count  out  WIDTH  last accepted sample

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; locked=0, dir_up=0, err=0, err_cnt=0, turn_cnt=0, last_count=0. rst overrides clear and in_valid.
- clear=1 (rst=0): same effect as reset. Any sample present that cycle is ignored.
- Samples are consumed only when in_valid=1. While in_valid=0: state, counters and last_count hold, and err is driven 0.
- All outputs are registered. The effect of a sample is visible one cycle after the edge that accepts it.
- last_count <= count on every accepted sample, in every state.
- FSM states: IDLE, SYNC, UP, DOWN. locked=1 exactly in UP and DOWN. dir_up=1 exactly in UP.
  IDLE, on a valid sample s:
    - s==MAX_VAL -> DOWN
    - s==MIN_VAL -> UP
    - otherwise -> SYNC
    - never flags an error.
  SYNC (prev = last_count), on a valid sample s:
    - s==prev+1 -> UP, or DOWN if s==MAX_VAL (counts a turn)
    - s==prev-1 -> DOWN, or UP if s==MIN_VAL (counts a turn)
    - otherwise -> err=1, err_cnt++, stay in SYNC
  UP (expect prev+1):
    - s==prev+1 and s==MAX_VAL -> DOWN, turn_cnt++
    - s==prev+1 otherwise -> stay in UP
    - otherwise -> err=1, err_cnt++, go to SYNC (resynchronise from s)
  DOWN (expect prev-1): symmetric to UP. On s==prev-1 and s==MIN_VAL -> UP, turn_cnt++.
- Arithmetic: prev+1 and prev-1 are computed in WIDTH+1 bits, so there is no modular wrap. For example, MAX=15 then 0 is an error, not a +1 step.
- A repeated value (s==prev) is an error in UP and DOWN, and a SYNC mismatch in SYNC.
- A sample outside [MIN_VAL, MAX_VAL] is always an error in SYNC, UP and DOWN. In IDLE it goes to SYNC with no error, and is flagged by the next sample if that sample is not adjacent.
- err_cnt holds at 2^ERR_W-1; further errors still pulse err. turn_cnt wraps to 0.
- Error and turn on the same sample cannot occur: a turn requires a legal step.

Test Plan:
- rst=1 for 2 cycles, then 1 -> all outputs 0 and state IDLE. Feed 0,1,...,15,14,...,0,1 with in_valid=1 -> locked=1 from the cycle after sample 0; dir_up goes 0 after 15 and 1 after 0; turn_cnt=2; err never pulses; err_cnt=0.
- Start mid-stream with 7,8,9 -> after 7: locked=0 (SYNC); after 8: locked=1, dir_up=1; no error.
- In UP, inject 3,4,6,7,8 -> exactly one err pulse, one cycle after the 6 is accepted; err_cnt=1, locked=0; after 7: locked=1, dir_up=1.
- Wrap check: 14,15,0 -> the 15 causes a turn (turn_cnt=1, dir_up=0); the 0 causes err=1 and err_cnt=1.
- in_valid low gaps: 2, gap x3, 3, gap, 4 -> no errors, last_count=4, outputs hold during gaps. Present an illegal count with in_valid=0 -> ignored.
- ERR_W=2 with 5 errors -> err_cnt saturates at 3 and err pulses 5 times. clear=1 mid-stream -> next cycle err_cnt=0, turn_cnt=0, locked=0. rst and clear asserted together -> reset result.

Source files
------------

// File: rtl/updown_seq_checker.sv
// updown_seq_checker: watches the value stream of an up/down triangle counter
// and checks that each accepted sample is a legal +1/-1 step, reversing only
// at MAX_VAL and MIN_VAL. Reports lock/direction, error pulses, a saturating
// error count and a wrapping turnaround count. All outputs are registered.
module updown_seq_checker #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 15,
  parameter int MIN_VAL = 0,
  parameter int ERR_W   = 8,
  parameter int TURN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  count,
  output logic              locked,
  output logic              dir_up,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [TURN_W-1:0] turn_cnt,
  output logic [WIDTH-1:0]  last_count
);

  typedef enum logic [1:0] {IDLE, SYNC, UP, DOWN} state_t;

  localparam logic [WIDTH:0]   MAX_E = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MIN_E = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH+1:0] MIN_X = (WIDTH+2)'(MIN_VAL);

  state_t              state_reg;
  logic                locked_reg;
  logic                dir_up_reg;
  logic                err_reg;
  logic [ERR_W-1:0]    err_cnt_reg;
  logic [TURN_W-1:0]   turn_cnt_reg;
  logic [WIDTH-1:0]    last_count_reg;

  // Step arithmetic is one bit wider than the sample so 15->0 is never a +1.
  logic [WIDTH:0]   s_ext;
  logic [WIDTH:0]   prev_p1;
  logic [WIDTH:0]   prev_m1;
  logic [WIDTH+1:0] lo_diff;
  logic             in_range;
  logic             at_max;
  logic             at_min;
  logic             step_up_ok;
  logic             step_dn_ok;

  assign s_ext      = {1'b0, count};
  assign prev_p1    = {1'b0, last_count_reg} + 1'b1;
  assign prev_m1    = {1'b0, last_count_reg} - 1'b1;
  // Lower bound via borrow bit: avoids a constant compare when MIN_VAL is 0.
  assign lo_diff    = {2'b00, count} - MIN_X;
  assign in_range   = ~lo_diff[WIDTH+1] && (s_ext <= MAX_E);
  assign at_max     = (s_ext == MAX_E);
  assign at_min     = (s_ext == MIN_E);
  assign step_up_ok = in_range && (s_ext == prev_p1);
  assign step_dn_ok = in_range && (s_ext == prev_m1);

  // Tracking FSM plus all registered outputs and counters.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_reg      <= IDLE;
      locked_reg     <= 1'b0;
      dir_up_reg     <= 1'b0;
      err_reg        <= 1'b0;
      err_cnt_reg    <= '0;
      turn_cnt_reg   <= '0;
      last_count_reg <= '0;
    end else begin
      err_reg <= 1'b0;
      if (in_valid) begin
        last_count_reg <= count;
        case (state_reg)
          IDLE: begin
            // First sample only picks a direction when it sits on a bound.
            if (at_max) begin
              state_reg <= DOWN; locked_reg <= 1'b1; dir_up_reg <= 1'b0;
            end else if (at_min) begin
              state_reg <= UP;   locked_reg <= 1'b1; dir_up_reg <= 1'b1;
            end else begin
              state_reg <= SYNC; locked_reg <= 1'b0; dir_up_reg <= 1'b0;
            end
          end
          SYNC: begin
            if (step_up_ok) begin
              locked_reg <= 1'b1;
              if (at_max) begin
                state_reg <= DOWN; dir_up_reg <= 1'b0;
                turn_cnt_reg <= turn_cnt_reg + 1'b1;
              end else begin
                state_reg <= UP;   dir_up_reg <= 1'b1;
              end
            end else if (step_dn_ok) begin
              locked_reg <= 1'b1;
              if (at_min) begin
                state_reg <= UP;   dir_up_reg <= 1'b1;
                turn_cnt_reg <= turn_cnt_reg + 1'b1;
              end else begin
                state_reg <= DOWN; dir_up_reg <= 1'b0;
              end
            end else begin
              err_reg <= 1'b1;
              if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + 1'b1;
              state_reg <= SYNC; locked_reg <= 1'b0; dir_up_reg <= 1'b0;
            end
          end
          UP: begin
            if (step_up_ok) begin
              if (at_max) begin
                state_reg <= DOWN; dir_up_reg <= 1'b0;
                turn_cnt_reg <= turn_cnt_reg + 1'b1;
              end
            end else begin
              err_reg <= 1'b1;
              if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + 1'b1;
              state_reg <= SYNC; locked_reg <= 1'b0; dir_up_reg <= 1'b0;
            end
          end
          DOWN: begin
            if (step_dn_ok) begin
              if (at_min) begin
                state_reg <= UP; dir_up_reg <= 1'b1;
                turn_cnt_reg <= turn_cnt_reg + 1'b1;
              end
            end else begin
              err_reg <= 1'b1;
              if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + 1'b1;
              state_reg <= SYNC; locked_reg <= 1'b0; dir_up_reg <= 1'b0;
            end
          end
          default: begin
            state_reg <= IDLE; locked_reg <= 1'b0; dir_up_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked     = locked_reg;
  assign dir_up     = dir_up_reg;
  assign err        = err_reg;
  assign err_cnt    = err_cnt_reg;
  assign turn_cnt   = turn_cnt_reg;
  assign last_count = last_count_reg;

endmodule
